// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC sequencer, synchronous imem read port, PC-tagged prefetch FIFO.
// Optional performance counters are enabled with the IF_PERF_CNT_EN macro.
module if_prefetch #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              halting,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_fpc;
  logic [ADDR_W-1:0] r_ipc;
  logic              r_inflight;
  logic              r_kill;
  logic [DATA_W-1:0] r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  logic w_issue;
  logic w_push;
  logic w_pop;

  // Credit counts the outstanding read so a returning word always has a free slot.
  assign w_issue   = !rst && !halting && !taken &&
                     ((r_count + CW'(r_inflight)) < CW'(DEPTH));
  assign w_push    = r_inflight && !r_kill && !taken;
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;

  assign imem_en   = w_issue;
  assign imem_addr = r_fpc;
  assign out_inst  = r_inst_mem[r_rd_ptr];
  assign out_pc    = r_pc_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc      <= '0;
      r_ipc      <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (taken) begin
        r_fpc <= br_addr;
      end else if (w_issue) begin
        r_fpc <= r_fpc + 1'b1;
        r_ipc <= r_fpc;
      end
      r_inflight <= w_issue;
      r_kill     <= taken;
      if (taken) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset; the count alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_inst_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]   <= r_ipc;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop) r_fetch_cnt <= r_fetch_cnt + 1'b1;
      if (taken) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
